// File: rtl/vram_line_arbiter.sv
// vram_line_arbiter: arbitrates the off-chip SRAM between GPU pixel accesses and display line fetches
//   A line request streams LINE_W pixels of one VRAM row into an external line buffer;
//   with GPU_SLOT != 0 every GPU_SLOT-th line cycle is offered to a waiting GPU request.
//   Optional feature macro: VRAM_LINE_SCALE_EN (horizontal scaling of the source x by dis_w/LINE_W).
// Ports:
//   clk, rst                                         clock, synchronous active-high reset
//   gpu_req/gpu_we/gpu_addr/gpu_wdata                GPU request (held until gpu_gnt)
//   gpu_gnt/gpu_rvalid/gpu_rdata                     grant, read data one cycle after a read grant
//   line_req/line_y/x_tl/dis_w                       line fetch start pulse and its parameters
//   line_busy/line_done/line_overrun                 fetch status pulses
//   pix_we/pix_x/pix_rgb                             line buffer write port (RGB888 from 5:5:5)
//   sram_addr/sram_dq_in/sram_dq_out/sram_dq_oe      SRAM address and data
//   sram_ce_n/sram_lb_n/sram_ub_n/sram_oe_n/sram_we_n SRAM control, active low
module vram_line_arbiter #(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 16,
  parameter int LINE_W    = 640,
  parameter int ROW_SHIFT = 10,
  parameter int GPU_SLOT  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    gpu_req,
  input  logic                    gpu_we,
  input  logic [ADDR_W-1:0]       gpu_addr,
  input  logic [DATA_W-1:0]       gpu_wdata,
  output logic                    gpu_gnt,
  output logic                    gpu_rvalid,
  output logic [DATA_W-1:0]       gpu_rdata,
  input  logic                    line_req,
  input  logic [ADDR_W-ROW_SHIFT-1:0] line_y,
  input  logic [ROW_SHIFT-1:0]    x_tl,
  input  logic [ROW_SHIFT-1:0]    dis_w,
  output logic                    line_busy,
  output logic                    line_done,
  output logic                    line_overrun,
  output logic                    pix_we,
  output logic [9:0]              pix_x,
  output logic [23:0]             pix_rgb,
  output logic [ADDR_W-1:0]       sram_addr,
  input  logic [DATA_W-1:0]       sram_dq_in,
  output logic [DATA_W-1:0]       sram_dq_out,
  output logic                    sram_dq_oe,
  output logic                    sram_ce_n,
  output logic                    sram_lb_n,
  output logic                    sram_ub_n,
  output logic                    sram_oe_n,
  output logic                    sram_we_n
);
  localparam int Y_W  = ADDR_W - ROW_SHIFT;
  localparam int FX_W = 10;
  localparam int SC_W = GPU_SLOT > 1 ? $clog2(GPU_SLOT) : 1;
  typedef enum logic {S_IDLE, S_LINE} state_t;
  state_t                r_state, w_state_n;
  logic [Y_W-1:0]        r_y;
  logic [ROW_SHIFT-1:0]  r_x_tl, r_dis_w, w_src_x;
  logic [FX_W-1:0]       r_fx;
  logic [SC_W-1:0]       r_sc;
  logic                  r_gpu_rvalid, r_pix_we, r_line_done, r_line_overrun;
  logic [DATA_W-1:0]     r_gpu_rdata;
  logic [9:0]            r_pix_x;
  logic [23:0]           r_pix_rgb;
  logic                  w_slot, w_gpu_go, w_fetch, w_last;
`ifdef VRAM_LINE_SCALE_EN
  localparam int P_W = FX_W + ROW_SHIFT;
  assign w_src_x = ROW_SHIFT'((P_W'(r_fx) * P_W'(r_dis_w)) / P_W'(LINE_W)) + r_x_tl;
`else
  logic w_unused_dis_w;
  assign w_unused_dis_w = ^r_dis_w;
  assign w_src_x = ROW_SHIFT'(r_fx) + r_x_tl;
`endif
  assign w_last = r_fx == FX_W'(LINE_W - 1);
  // GPU slot is the last cycle of each GPU_SLOT-cycle group; never with interleave disabled
  assign w_slot = (GPU_SLOT != 0) && r_state == S_LINE && r_sc == SC_W'(GPU_SLOT - 1);
  always_comb begin
    w_gpu_go  = gpu_req && !rst && (r_state == S_IDLE || w_slot);
    w_fetch   = !rst && r_state == S_LINE && !w_gpu_go;
    w_state_n = r_state;
    if (r_state == S_IDLE && line_req) w_state_n = S_LINE;
    if (w_fetch && w_last) w_state_n = S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_y            <= '0;
      r_x_tl         <= '0;
      r_dis_w        <= '0;
      r_fx           <= '0;
      r_sc           <= '0;
      r_gpu_rvalid   <= 1'b0;
      r_gpu_rdata    <= '0;
      r_pix_we       <= 1'b0;
      r_pix_x        <= '0;
      r_pix_rgb      <= '0;
      r_line_done    <= 1'b0;
      r_line_overrun <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_sc    <= (r_state == S_LINE && r_sc != SC_W'(GPU_SLOT - 1)) ? r_sc + 1'b1 : '0;
      r_fx    <= (r_state == S_IDLE) ? '0 : r_fx + FX_W'(w_fetch);
      if (r_state == S_IDLE && line_req) begin
        r_y     <= line_y;
        r_x_tl  <= x_tl;
        r_dis_w <= dis_w;
      end
      r_gpu_rvalid <= w_gpu_go && !gpu_we;
      if (w_gpu_go && !gpu_we) r_gpu_rdata <= sram_dq_in;
      r_pix_we <= w_fetch;
      if (w_fetch) begin
        r_pix_x   <= 10'(r_fx);
        r_pix_rgb <= {sram_dq_in[14:10], 3'b0, sram_dq_in[9:5], 3'b0, sram_dq_in[4:0], 3'b0};
      end
      r_line_done    <= w_fetch && w_last;
      r_line_overrun <= line_req && r_state == S_LINE;
    end
  end
  assign gpu_gnt      = w_gpu_go;
  assign gpu_rvalid   = r_gpu_rvalid;
  assign gpu_rdata    = r_gpu_rdata;
  assign line_busy    = r_state == S_LINE;
  assign line_done    = r_line_done;
  assign line_overrun = r_line_overrun;
  assign pix_we       = r_pix_we;
  assign pix_x        = r_pix_x;
  assign pix_rgb      = r_pix_rgb;
  assign sram_addr    = w_gpu_go ? gpu_addr : w_fetch ? {r_y, w_src_x} : '0;
  assign sram_dq_out  = gpu_wdata;
  assign sram_dq_oe   = w_gpu_go && gpu_we;
  assign sram_we_n    = !(w_gpu_go && gpu_we);
  assign sram_oe_n    = !(w_fetch || (w_gpu_go && !gpu_we));
  assign sram_ce_n    = 1'b0;
  assign sram_lb_n    = 1'b0;
  assign sram_ub_n    = 1'b0;
endmodule

// File: tb/tb_vram_line_arbiter.sv
// tb_vram_line_arbiter: two arbiters (GPU_SLOT 0 and 4) under shared line stimulus, checked against a slot/line model
module tb_vram_line_arbiter;
  localparam int LW = 640;
  typedef struct packed {logic w; logic [19:0] a; logic [15:0] d;} op_t;
  logic clk = 0, rst = 1, line_req = 0;
  logic [9:0] line_y = 0, x_tl = 0, dis_w = 0;
  logic [1:0] req = 0, we = 0, gnt, rv, busy, done, ovr, pwe, oe, ce, lb, ub, oen, wen;
  logic [19:0] ga [2], sa [2];
  logic [15:0] gd [2], rd [2], dqo [2], dqi [2];
  logic [9:0] px [2];
  logic [23:0] rgb [2];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : gi
    vram_line_arbiter #(.GPU_SLOT(g * 4)) u_dut (
      .clk(clk), .rst(rst), .gpu_req(req[g]), .gpu_we(we[g]), .gpu_addr(ga[g]), .gpu_wdata(gd[g]),
      .gpu_gnt(gnt[g]), .gpu_rvalid(rv[g]), .gpu_rdata(rd[g]), .line_req(line_req), .line_y(line_y),
      .x_tl(x_tl), .dis_w(dis_w), .line_busy(busy[g]), .line_done(done[g]), .line_overrun(ovr[g]),
      .pix_we(pwe[g]), .pix_x(px[g]), .pix_rgb(rgb[g]), .sram_addr(sa[g]), .sram_dq_in(dqi[g]),
      .sram_dq_out(dqo[g]), .sram_dq_oe(oe[g]), .sram_ce_n(ce[g]), .sram_lb_n(lb[g]), .sram_ub_n(ub[g]),
      .sram_oe_n(oen[g]), .sram_we_n(wen[g]));
  end
  logic [15:0] sm [int], rm [int];
  bit mb [2];
  int mk [2], mn [2];
  logic [9:0] my [2], mx [2], md [2];
  logic e_pwe [2], e_done [2], e_rv [2], e_ovr [2];
  logic [9:0] e_px [2];
  logic [23:0] e_rgb [2];
  logic [15:0] e_rd [2], lrd [2];
  logic [19:0] a0 [2], a1 [2], a30 [2];
  int start [2], lat [2], gcnt [2], dcnt [2], ocnt [2], qi [2];
  bit fq [2], gs [2];
  op_t ops [$];
  int n_chk = 0, n_fail = 0, ncyc = 0, mode = 0;
  bit en = 0;
  logic p_lr = 0, p_rst = 1;
  task automatic chk(string t, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", t, a, e, ncyc);
    end
  endtask
  function automatic logic [15:0] pat(int a);
    return 16'(a * 40503 + (a >>> 7));
  endfunction
  function automatic logic [23:0] to_rgb(logic [15:0] v);
    return {v[14:10], 3'b0, v[9:5], 3'b0, v[4:0], 3'b0};
  endfunction
  function automatic logic [9:0] srcx(int n, logic [9:0] x, logic [9:0] d);
`ifdef VRAM_LINE_SCALE_EN
    return 10'((n * int'(d)) / LW + int'(x));
`else
    return 10'(n + int'(x) + 0 * int'(d));
`endif
  endfunction
  task automatic drive(int g);
    if (req[g] && gs[g]) begin
      req[g] = 0;
      if (fq[g]) qi[g]++;
    end
    if (!req[g]) begin
      if (qi[g] < ops.size()) begin
        req[g] = 1; we[g] = ops[qi[g]].w; ga[g] = ops[qi[g]].a; gd[g] = ops[qi[g]].d; fq[g] = 1;
      end else if (mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0)) begin
        req[g] = 1; we[g] = 1'($urandom_range(0, 1)); ga[g] = 20'($urandom_range(0, 16383));
        gd[g] = 16'($urandom); fq[g] = 0;
      end
    end
  endtask
  task automatic step(int g);
    string s = g ? "s4." : "s0.";
    int sl = g * 4;
    int key = (g << 20) | int'(sa[g]);
    bit slot, go, fe;
    logic [19:0] ea;
    logic [15:0] v;
    if (!wen[g]) sm[key] = dqo[g];
    dqi[g] = sm.exists(key) ? sm[key] : pat(int'(sa[g]));
    slot = (sl != 0) ? (mb[g] && (mk[g] % (sl == 0 ? 1 : sl)) == sl - 1) : 1'b0;
    go = !rst && req[g] && (!mb[g] || slot);
    fe = !rst && mb[g] && !go;
    ea = go ? ga[g] : fe ? {my[g], srcx(mn[g], mx[g], md[g])} : 20'd0;
    if (en) begin
      chk({s, "pix_we"}, pwe[g], e_pwe[g]);
      chk({s, "pix_x"}, px[g], e_px[g]);
      chk({s, "pix_rgb"}, rgb[g], e_rgb[g]);
      chk({s, "line_done"}, done[g], e_done[g]);
      chk({s, "overrun"}, ovr[g], e_ovr[g]);
      chk({s, "rvalid"}, rv[g], e_rv[g]);
      chk({s, "rdata"}, rd[g], e_rd[g]);
      chk({s, "busy"}, busy[g], mb[g]);
      chk({s, "gnt"}, gnt[g], go);
      chk({s, "addr"}, sa[g], ea);
      chk({s, "we_n"}, wen[g], !(go && we[g]));
      chk({s, "oe_n"}, oen[g], !(fe || (go && !we[g])));
      chk({s, "dq_oe"}, oe[g], go && we[g]);
      chk({s, "ce_lb_ub"}, {ce[g], lb[g], ub[g]}, 0);
      if (go && we[g]) chk({s, "dq_out"}, dqo[g], gd[g]);
    end
    if (fe && mn[g] == 0) a0[g] = sa[g];
    if (fe && mn[g] == 1) a1[g] = sa[g];
    if (fe && mn[g] == 30) a30[g] = sa[g];
    if (rv[g]) lrd[g] = rd[g];
    if (done[g]) begin dcnt[g]++; lat[g] = ncyc - start[g]; end
    if (ovr[g]) ocnt[g]++;
    if (gnt[g] && mb[g]) gcnt[g]++;
    gs[g] = gnt[g];
    key = (g << 20) | int'(ea);
    v = rm.exists(key) ? rm[key] : pat(int'(ea));
    if (rst) begin
      e_pwe[g] = 0; e_done[g] = 0; e_rv[g] = 0; e_ovr[g] = 0; e_px[g] = 0; e_rgb[g] = 0; e_rd[g] = 0; mb[g] = 0;
    end else begin
      e_rv[g] = go && !we[g];
      if (go && !we[g]) e_rd[g] = v;
      if (go && we[g]) rm[key] = gd[g];
      e_pwe[g] = fe;
      if (fe) begin e_px[g] = 10'(mn[g]); e_rgb[g] = to_rgb(v); end
      e_done[g] = fe && mn[g] == LW - 1;
      e_ovr[g] = line_req && mb[g];
      if (mb[g]) begin
        mk[g]++;
        if (fe) mn[g]++;
        if (mn[g] == LW) mb[g] = 0;
      end else if (line_req) begin
        mb[g] = 1; mk[g] = 0; mn[g] = 0; my[g] = line_y; mx[g] = x_tl; md[g] = dis_w;
        start[g] = ncyc; gcnt[g] = 0;
      end
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #2;
    rst = p_rst;
    line_req = p_lr;
    for (int g = 0; g < 2; g++) drive(g);
    #3;
    for (int g = 0; g < 2; g++) step(g);
    ncyc++;
  endtask
  task automatic pulse_line(logic [9:0] y, logic [9:0] x, logic [9:0] d);
    line_y = y; x_tl = x; dis_w = d; p_lr = 1;
    cyc();
    p_lr = 0;
  endtask
  task automatic wait_done(int lim);
    int d0 = dcnt[0], d1 = dcnt[1];
    for (int i = 0; i < lim && !(dcnt[0] > d0 && dcnt[1] > d1); i++) cyc();
    chk("done_timeout", dcnt[0] > d0 && dcnt[1] > d1, 1);
  endtask
  initial begin
    int o0, o1, d0, d1;
    bit hit;
    for (int g = 0; g < 2; g++) begin ga[g] = 0; gd[g] = 0; end
    cyc();
    en = 1;
    cyc();
    p_rst = 0;
    ops.push_back(op_t'{w: 1'b1, a: 20'h00123, d: 16'h7C1F});
    ops.push_back(op_t'{w: 1'b0, a: 20'h00123, d: 16'h0000});
    repeat (6) cyc();
    chk("s0.wr_rd", lrd[0], 16'h7C1F);
    chk("s4.wr_rd", lrd[1], 16'h7C1F);
    mode = 1;
    pulse_line(5, 0, 640);
    wait_done(1200);
    chk("s0.latency", lat[0], 641);
    chk("s4.latency", lat[1], 854);
    chk("s0.gpu_in_line", gcnt[0], 0);
    chk("s4.gpu_in_line", gcnt[1], 213);
    mode = 0;
    repeat (4) cyc();
    o0 = ocnt[0]; o1 = ocnt[1];
    pulse_line(9, 1000, 640);
    repeat (10) cyc();
    pulse_line(2, 5, 100);
    wait_done(1200);
    chk("s0.overrun_cnt", ocnt[0] - o0, 1);
    chk("s4.overrun_cnt", ocnt[1] - o1, 1);
`ifndef VRAM_LINE_SCALE_EN
    chk("s0.wrap_x30", a30[0], {10'd9, 10'd6});
    chk("s4.wrap_x30", a30[1], {10'd9, 10'd6});
`endif
    repeat (4) cyc();
    pulse_line(3, 17, 320);
    hit = 0;
    for (int i = 0; i < 400 && !hit; i++) begin
      cyc();
      hit = pwe[1] && px[1] == 100;
    end
    chk("px100_timeout", hit, 1);
    p_rst = 1;
    cyc();
    p_rst = 0;
    d0 = dcnt[0]; d1 = dcnt[1];
    repeat (700) cyc();
    chk("s0.rst_no_done", dcnt[0], d0);
    chk("s4.rst_no_done", dcnt[1], d1);
    chk("rst_busy", busy, 0);
`ifdef VRAM_LINE_SCALE_EN
    chk("s0.scale_x0", a0[0], {10'd3, 10'd17});
    chk("s0.scale_x1", a1[0], {10'd3, 10'd17});
    chk("s4.scale_x0", a0[1], {10'd3, 10'd17});
    chk("s4.scale_x1", a1[1], {10'd3, 10'd17});
`endif
    mode = 2;
    for (int it = 0; it < 6; it++) begin
      pulse_line(10'($urandom_range(0, 15)), 10'($urandom), 10'($urandom));
      for (int c = 0; c < int'($urandom_range(200, 900)); c++) begin
        if ($urandom_range(0, 249) == 0) begin
          line_y = 10'($urandom_range(0, 15)); x_tl = 10'($urandom); dis_w = 10'($urandom); p_lr = 1;
        end else p_lr = 0;
        cyc();
      end
      p_lr = 0;
    end
    mode = 0;
    repeat (1000) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
